device_arbiter_pipelined: RTL

Parametrised N-controller to one-device bus arbiter that sits between the controllers (N64 PI, USB PC, SD DMA, …) and a single memory or register device in the top level. Each controller whose bank field matches the device's bank competes for the device. A winner is granted in the same cycle. Read acks are routed back to the issuing controller through an in-order ID FIFO, so up to MAX_OUTSTANDING reads may be in flight. This is the pipelined, wider successor of the single-outstanding device arbiter.

---
 rtl/device_arbiter_pipelined_pkg.sv | 17 +
 rtl/device_arbiter_pipelined_id_fifo.sv | 70 +++++++
 rtl/device_arbiter_pipelined.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/device_arbiter_pipelined_pkg.sv
// Shared constants for the device arbiter: bank codes, bank field width and
// the controller-ID width helper used by the arbiter and its read-ID FIFO.
package device_arbiter_pipelined_pkg;

    localparam int BANK_WIDTH = 4;

    localparam logic [BANK_WIDTH-1:0] BANK_SDRAM  = 4'd1;
    localparam logic [BANK_WIDTH-1:0] BANK_CART   = 4'd2;
    localparam logic [BANK_WIDTH-1:0] BANK_EEPROM = 4'd3;
    localparam logic [BANK_WIDTH-1:0] BANK_SD     = 4'd4;

    // A single controller still needs a 1-bit ID so the FIFO has nonzero width.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/device_arbiter_pipelined_id_fifo.sv
// In-order FIFO of controller IDs for reads that are in flight at the device.
// A push into a full FIFO is only legal when a pop happens in the same cycle.
module arbiter_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_id,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) begin
            mem_d[wr_ptr_q] = i_push_id;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (i_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({i_push, i_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/device_arbiter_pipelined.sv
// N-controller to one-device arbiter with up to MAX_OUTSTANDING reads in flight.
// Define ARBITER_ROUND_ROBIN_EN for round-robin grant; otherwise lowest index wins.
module device_arbiter_pipelined #(
    parameter int NUM_CONTROLLERS = 3,
    parameter int ADDRESS_WIDTH   = 25,
    parameter int DATA_WIDTH      = 32,
    parameter int BANK_WIDTH      = device_arbiter_pipelined_pkg::BANK_WIDTH,
    parameter int DEVICE_BANK     = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    input  logic [NUM_CONTROLLERS-1:0]              i_request,
    input  logic [NUM_CONTROLLERS-1:0]              i_write,
    output logic [NUM_CONTROLLERS-1:0]              o_busy,
    output logic [NUM_CONTROLLERS-1:0]              o_ack,
    input  logic [NUM_CONTROLLERS*BANK_WIDTH-1:0]   i_bank,
    input  logic [NUM_CONTROLLERS*ADDRESS_WIDTH-1:0] i_address,
    input  logic [NUM_CONTROLLERS*DATA_WIDTH-1:0]   i_data,
    output logic [NUM_CONTROLLERS*DATA_WIDTH-1:0]   o_data,
    output logic                                    o_device_request,
    output logic                                    o_device_write,
    input  logic                                    i_device_busy,
    input  logic                                    i_device_ack,
    output logic [ADDRESS_WIDTH-1:0]                o_device_address,
    input  logic [DATA_WIDTH-1:0]                   i_device_data,
    output logic [DATA_WIDTH-1:0]                   o_device_data,
    output logic                                    o_error
);

    import device_arbiter_pipelined_pkg::*;

    localparam int N   = NUM_CONTROLLERS;
    localparam int AW  = ADDRESS_WIDTH;
    localparam int DW  = DATA_WIDTH;
    localparam int BW  = BANK_WIDTH;
    localparam int IDW = id_width(NUM_CONTROLLERS);

    logic [N-1:0]   eligible;
    logic           grant_valid;
    logic [IDW-1:0] grant_idx;
    logic           can_issue;
    logic           accept;
    logic           push;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [IDW-1:0] fifo_head;
    logic           error_q, error_d;

    always_comb begin
        eligible = '0;
        for (int k = 0; k < N; k++) begin
            eligible[k] = i_request[k] && (i_bank[k*BW +: BW] == BW'(DEVICE_BANK));
        end
    end

`ifdef ARBITER_ROUND_ROBIN_EN
    logic [IDW-1:0] last_grant_q, last_grant_d;

    // Search offsets from last_grant+1 upward, wrapping past N-1 to 0.
    always_comb begin
        int start_idx;
        start_idx   = (int'(last_grant_q) + 1) % N;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!grant_valid && eligible[j] && (j == (start_idx + i) % N)) begin
                    grant_valid = 1'b1;
                    grant_idx   = IDW'(j);
                end
            end
        end
    end

    always_comb begin
        last_grant_d = accept ? grant_idx : last_grant_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_grant_q <= IDW'(N - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (eligible[j]) begin
                grant_valid = 1'b1;
                grant_idx   = IDW'(j);
            end
        end
    end
`endif

    always_comb begin
        o_device_write   = 1'b0;
        o_device_address = '0;
        o_device_data    = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_valid && (grant_idx == IDW'(k))) begin
                o_device_write   = i_write[k];
                o_device_address = i_address[k*AW +: AW];
                o_device_data    = i_data[k*DW +: DW];
            end
        end
    end

    // A full FIFO may still issue when an ack frees a slot this same cycle.
    assign can_issue        = !fifo_full || i_device_ack;
    assign o_device_request = grant_valid && can_issue && !i_reset;
    assign accept           = o_device_request && !i_device_busy;
    assign push             = accept && !o_device_write;
    assign pop              = i_device_ack && !fifo_empty && !i_reset;

    always_comb begin
        o_busy = '0;
        o_ack  = '0;
        o_data = '0;
        for (int k = 0; k < N; k++) begin
            o_busy[k] = eligible[k] && !(accept && (grant_idx == IDW'(k)));
            if (pop && (fifo_head == IDW'(k))) begin
                o_ack[k]            = 1'b1;
                o_data[k*DW +: DW]  = i_device_data;
            end
        end
    end

    always_comb begin
        error_d = error_q || (i_device_ack && fifo_empty);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign o_error = error_q;

    arbiter_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW)
    ) u_id_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_push    (push),
        .i_push_id (grant_idx),
        .i_pop     (pop),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_head    (fifo_head)
    );

endmodule
